layer_compositor: RTL and testbench

Parametrised N-layer pixel compositor and game-screen controller. It is the successor to the fixed per-sprite display mux. It takes already-rendered layer colours for the current (hcount, vcount), resolves priority, colour-key transparency and per-layer 50% blending, and overlays the arena border. It also runs a START/PLAY/GAME_OVER screen FSM driven by IR codes and health, and applies a damage-flash tint. It sits between the sprite/health/trace renderers and the video output stage.

---
 rtl/layer_compositor_pkg.sv | 27 ++
 rtl/layer_compositor_screen_fsm.sv | 85 ++++++++
 rtl/layer_compositor.sv | 124 ++++++++++++
 tb/tb_layer_compositor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared types, IR defaults and channel helpers for the layer compositor.
package layer_compositor_pkg;

    typedef enum logic [1:0] {
        START     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } screen_state_t;

    localparam logic [31:0] IR_CODE_A_DEF = 32'h20DF_5BA4;
    localparam logic [31:0] IR_CODE_B_DEF = 32'h20DF_5AA5;

    // 50/50 mix of one 8-bit channel; the carry is kept so the sum never wraps.
    function automatic logic [7:0] blend50(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8:1];
    endfunction

    // Channel-wise 50/50 mix of two packed RGB888 pixels.
    function automatic logic [23:0] blend_px(input logic [23:0] a, input logic [23:0] b);
        return {blend50(a[23:16], b[23:16]),
                blend50(a[15:8],  b[15:8]),
                blend50(a[7:0],   b[7:0])};
    endfunction

endpackage

// File: rtl/layer_compositor_screen_fsm.sv
// Screen-state FSM (START/PLAY/GAME_OVER) with game-over hold timer and damage flash.
module screen_fsm
    import layer_compositor_pkg::*;
#(
    parameter int          FLASH_FRAMES     = 16,
    parameter int          OVER_HOLD_FRAMES = 60,
    parameter logic [31:0] IR_CODE_A        = IR_CODE_A_DEF,
    parameter logic [31:0] IR_CODE_B        = IR_CODE_B_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_nf,
    input  logic [31:0]   i_ir_code,
    input  logic          i_ir_valid,
    input  logic [2:0]    i_player_health,
    input  logic [2:0]    i_opponent_health,
    output screen_state_t o_state,
    output logic          o_flash_active,
    output logic          o_flash_red
);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] HOLD_MIN   = 8'(OVER_HOLD_FRAMES);

    screen_state_t r_state;
    screen_state_t w_state_nxt;
    logic [7:0]    r_hold, w_hold_nxt;
    logic [7:0]    r_flash, w_flash_nxt;
    logic [2:0]    r_prev_p, r_prev_o;
    logic          w_ir_hit, w_dmg, w_dead;

    assign w_ir_hit = i_ir_valid && ((i_ir_code == IR_CODE_A) || (i_ir_code == IR_CODE_B));
    assign w_dmg    = (i_player_health < r_prev_p) || (i_opponent_health < r_prev_o);
    assign w_dead   = (i_player_health == 3'd0) || (i_opponent_health == 3'd0);

    // State, counters and previous-health registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= START;
            r_hold   <= 8'd0;
            r_flash  <= 8'd0;
            r_prev_p <= 3'd7;
            r_prev_o <= 3'd7;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_flash  <= w_flash_nxt;
            r_prev_p <= i_player_health;
            r_prev_o <= i_opponent_health;
        end
    end

    // Next state and counter updates; only the current state's rule is evaluated.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_flash_nxt = r_flash;
        case (r_state)
            START:     if (w_ir_hit) w_state_nxt = PLAY;
            PLAY:      if (i_nf && w_dead) w_state_nxt = GAME_OVER;
            GAME_OVER: if (w_ir_hit && (r_hold >= HOLD_MIN)) w_state_nxt = START;
            default:   w_state_nxt = START;
        endcase

        if ((r_state != GAME_OVER) && (w_state_nxt == GAME_OVER))
            w_hold_nxt = 8'd0;
        else if ((r_state == GAME_OVER) && i_nf && (r_hold != 8'hFF))
            w_hold_nxt = r_hold + 8'd1;

        // A damage load beats the frame decrement; leaving PLAY drops the flash.
        if ((r_state == PLAY) && (w_state_nxt == PLAY)) begin
            if (w_dmg)
                w_flash_nxt = FLASH_LOAD;
            else if (i_nf && (r_flash != 8'd0))
                w_flash_nxt = r_flash - 8'd1;
        end else begin
            w_flash_nxt = 8'd0;
        end
    end

    assign o_state        = r_state;
    assign o_flash_active = (r_flash != 8'd0);
    assign o_flash_red    = r_flash[1];

endmodule

// File: rtl/layer_compositor.sv
// Two-stage N-layer pixel compositor with border overlay, screen modifier and damage tint.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int          NUM_LAYERS       = 8,
    parameter int          COLOR_W          = 24,
    parameter int          BORDER_X         = 960,
    parameter int          BORDER_Y         = 640,
    parameter logic [23:0] BORDER_COLOR     = 24'hFF_FF_FF,
    parameter logic [23:0] KEY_COLOR        = 24'h00_00_00,
    parameter int          FLASH_FRAMES     = 16,
    parameter int          OVER_HOLD_FRAMES = 60,
    parameter logic [31:0] IR_CODE_A        = IR_CODE_A_DEF,
    parameter logic [31:0] IR_CODE_B        = IR_CODE_B_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layers_in,
    input  logic [NUM_LAYERS-1:0]         layer_en_in,
    input  logic [NUM_LAYERS-1:0]         blend_in,
    input  logic [COLOR_W-1:0]            start_pixel_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          nf_in,
    input  logic [31:0]                   ir_code_in,
    input  logic                          ir_valid_in,
    input  logic [2:0]                    player_health_in,
    input  logic [2:0]                    opponent_health_in,
    output logic [COLOR_W-1:0]            pixel_out,
    output logic [1:0]                    screen_state_out,
    output logic                          flash_active_out
);

    localparam logic [10:0] BX = 11'(BORDER_X);
    localparam logic [9:0]  BY = 10'(BORDER_Y);

    logic [NUM_LAYERS*COLOR_W-1:0] r_lay_s1;
    logic [NUM_LAYERS-1:0]         r_en_s1, r_bl_s1;
    logic [COLOR_W-1:0]            r_start_s1;
    logic                          r_border_s1;
    logic [COLOR_W-1:0]            r_pixel;
    logic                          w_border;
    logic [COLOR_W-1:0]            w_acc, w_comp, w_pix;
    screen_state_t                 w_state;
    logic                          w_flash_active, w_flash_red;

    assign w_border = ((hcount_in == BX) && (vcount_in <= BY)) ||
                      ((vcount_in == BY) && (hcount_in <= BX));

    screen_fsm #(
        .FLASH_FRAMES     (FLASH_FRAMES),
        .OVER_HOLD_FRAMES (OVER_HOLD_FRAMES),
        .IR_CODE_A        (IR_CODE_A),
        .IR_CODE_B        (IR_CODE_B)
    ) u_fsm (
        .i_clk             (clk_in),
        .i_rst_n           (rst_n_in),
        .i_nf              (nf_in),
        .i_ir_code         (ir_code_in),
        .i_ir_valid        (ir_valid_in),
        .i_player_health   (player_health_in),
        .i_opponent_health (opponent_health_in),
        .o_state           (w_state),
        .o_flash_active    (w_flash_active),
        .o_flash_red       (w_flash_red)
    );

    // Stage 1: capture layer data, controls and the border flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_lay_s1    <= '0;
            r_en_s1     <= '0;
            r_bl_s1     <= '0;
            r_start_s1  <= '0;
            r_border_s1 <= 1'b0;
        end else begin
            r_lay_s1    <= layers_in;
            r_en_s1     <= layer_en_in;
            r_bl_s1     <= blend_in;
            r_start_s1  <= start_pixel_in;
            r_border_s1 <= w_border;
        end
    end

    // Composite from the background (highest index) up to layer 0.
    always_comb begin
        logic [COLOR_W-1:0] lay;
        w_acc = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            lay = r_lay_s1[i*COLOR_W +: COLOR_W];
            if (r_en_s1[i] && (lay != KEY_COLOR))
                w_acc = r_bl_s1[i] ? blend_px(lay, w_acc) : lay;
        end
    end

    // Border overlay, then screen-specific modifier and flash tint.
    always_comb begin
        w_comp = r_border_s1 ? BORDER_COLOR : w_acc;
        w_pix  = r_start_s1;
        case (w_state)
            START: w_pix = r_start_s1;
            PLAY: begin
                w_pix = w_comp;
                if (w_flash_active && w_flash_red)
                    w_pix[23:16] = 8'hFF;
            end
            GAME_OVER: w_pix = {1'b0, w_comp[23:17], 1'b0, w_comp[15:9], 1'b0, w_comp[7:1]};
            default:   w_pix = r_start_s1;
        endcase
    end

    // Stage 2: output pixel register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_pixel <= '0;
        else
            r_pixel <= w_pix;
    end

    assign pixel_out        = r_pixel;
    assign screen_state_out = w_state;
    assign flash_active_out = w_flash_active;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench: vector table through a pixel scoreboard plus FSM/flash/reset sequences.
module tb_layer_compositor;

    localparam int NL = 8;
    localparam int CW = 24;
    localparam int FLASH_N = 16;
    localparam int HOLD_N  = 60;
    localparam logic [31:0] CODE_A = 32'h20DF_5BA4;
    localparam logic [31:0] CODE_B = 32'h20DF_5AA5;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [NL*CW-1:0]  layers_in;
    logic [NL-1:0]     layer_en_in, blend_in;
    logic [CW-1:0]     start_pixel_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              nf_in;
    logic [31:0]       ir_code_in;
    logic              ir_valid_in;
    logic [2:0]        player_health_in, opponent_health_in;
    logic [CW-1:0]     pixel_out;
    logic [1:0]        screen_state_out;
    logic              flash_active_out;

    always #5 clk_in = ~clk_in;

    layer_compositor #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .FLASH_FRAMES(FLASH_N), .OVER_HOLD_FRAMES(HOLD_N)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .layers_in(layers_in),
        .layer_en_in(layer_en_in), .blend_in(blend_in), .start_pixel_in(start_pixel_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .nf_in(nf_in),
        .ir_code_in(ir_code_in), .ir_valid_in(ir_valid_in),
        .player_health_in(player_health_in), .opponent_health_in(opponent_health_in),
        .pixel_out(pixel_out), .screen_state_out(screen_state_out),
        .flash_active_out(flash_active_out)
    );

    typedef struct {
        logic [NL*CW-1:0] lay;
        logic [NL-1:0]    en;
        logic [NL-1:0]    bl;
        logic [10:0]      h;
        logic [9:0]       v;
        logic [CW-1:0]    exp;
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] sbq[$];
    logic          sb_push;
    logic [1:0]    sb_vld;
    vec_t          tbl[14];

    // Tracks which cycles carry a scoreboarded pixel through the 2-stage pipe.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) sb_vld <= 2'b00;
        else           sb_vld <= {sb_vld[0], sb_push};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [CW-1:0] e;
        @(negedge clk_in);
        if (sb_vld[1]) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got pixel %h expected no output", pixel_out);
            end else begin
                e = sbq.pop_front();
                chk("sb_pixel", 32'(pixel_out), 32'(e));
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic nf_pulse();
        nf_in = 1'b1;
        step();
        nf_in = 1'b0;
        step();
    endtask

    task automatic ir_send(input logic [31:0] code);
        ir_code_in  = code;
        ir_valid_in = 1'b1;
        step();
        ir_valid_in = 1'b0;
        ir_code_in  = 32'd0;
    endtask

    function automatic vec_t mkv(input int a, input logic [23:0] ca, input int b,
                                 input logic [23:0] cb, input logic [23:0] c7,
                                 input logic [7:0] en, input logic [7:0] bl,
                                 input int h, input int v, input logic [23:0] e);
        vec_t t;
        t.lay = '0;
        t.lay[7*CW +: CW] = c7;
        t.lay[b*CW +: CW] = cb;
        t.lay[a*CW +: CW] = ca;
        t.en  = en;
        t.bl  = bl;
        t.h   = 11'(h);
        t.v   = 10'(v);
        t.exp = e;
        return t;
    endfunction

    initial begin
        logic [7:0]  cnt;
        logic [23:0] fexp;

        tbl[0]  = mkv(0, 24'h00FF00, 1, 24'h000000, 24'h112233, 8'h81, 8'h00, 100, 100, 24'h00FF00);
        tbl[1]  = mkv(0, 24'h00FF00, 1, 24'h000000, 24'h112233, 8'h80, 8'h00, 100, 100, 24'h112233);
        tbl[2]  = mkv(0, 24'h000000, 1, 24'h000000, 24'h112233, 8'h81, 8'h00, 100, 100, 24'h112233);
        tbl[3]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h0000FE, 8'h84, 8'h04, 100, 100, 24'h7F007F);
        tbl[4]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h0000FE, 8'h84, 8'h04, 960, 100, 24'hFFFFFF);
        tbl[5]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h0000FE, 8'h84, 8'h04, 960, 641, 24'h7F007F);
        tbl[6]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h0000FE, 8'h84, 8'h04, 500, 640, 24'hFFFFFF);
        tbl[7]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h0000FE, 8'h84, 8'h04, 961, 640, 24'h7F007F);
        tbl[8]  = mkv(2, 24'hFF0000, 1, 24'h000000, 24'h000000, 8'h04, 8'h04, 0, 0, 24'h7F0000);
        tbl[9]  = mkv(1, 24'hABCDEF, 3, 24'h123456, 24'h112233, 8'h8A, 8'h00, 0, 0, 24'hABCDEF);
        tbl[10] = mkv(5, 24'h302010, 3, 24'h000000, 24'h102030, 8'hA8, 8'h20, 0, 0, 24'h202020);
        tbl[11] = mkv(1, 24'hABCDEF, 3, 24'h123456, 24'h112233, 8'h8A, 8'h00, 960, 640, 24'hFFFFFF);
        tbl[12] = mkv(0, 24'h808080, 1, 24'hFFFFFF, 24'h112233, 8'h83, 8'h01, 0, 0, 24'hBFBFBF);
        tbl[13] = mkv(0, 24'hFF0000, 1, 24'h000000, 24'h112233, 8'h80, 8'h01, 0, 0, 24'h112233);

        rst_n_in = 1'b0;
        layers_in = '0; layer_en_in = '0; blend_in = '0;
        start_pixel_in = 24'h0; hcount_in = 11'd0; vcount_in = 10'd0;
        nf_in = 1'b0; ir_code_in = 32'd0; ir_valid_in = 1'b0; sb_push = 1'b0;
        player_health_in = 3'd3; opponent_health_in = 3'd3;

        // Reset state
        #22;
        chk("rst_pixel", 32'(pixel_out), 32'h0);
        chk("rst_state", 32'(screen_state_out), 32'd0);
        chk("rst_flash", 32'(flash_active_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();

        // START: pixel follows start_pixel_in two cycles later
        layers_in = tbl[0].lay; layer_en_in = tbl[0].en;
        for (int i = 0; i < 4; i++) begin
            start_pixel_in = 24'h102030 + 24'(i) * 24'h010101;
            sbq.push_back(start_pixel_in);
            sb_push = 1'b1;
            step();
        end
        sb_push = 1'b0;
        cyc(2);

        ir_send(32'h1234_5678);
        chk("start_bad_ir", 32'(screen_state_out), 32'd0);
        chk("start_pre_ir", 32'(screen_state_out), 32'd0);
        ir_send(CODE_A);
        chk("start_to_play", 32'(screen_state_out), 32'd1);
        cyc(2);

        // PLAY: composition vectors back-to-back
        for (int i = 0; i < 14; i++) begin
            layers_in = tbl[i].lay; layer_en_in = tbl[i].en; blend_in = tbl[i].bl;
            hcount_in = tbl[i].h;   vcount_in = tbl[i].v;
            sbq.push_back(tbl[i].exp);
            sb_push = 1'b1;
            step();
        end
        sb_push = 1'b0;
        cyc(2);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        ir_send(CODE_B);
        chk("play_ir_ignored", 32'(screen_state_out), 32'd1);

        // Damage flash
        layers_in = tbl[1].lay; layer_en_in = 8'h80; blend_in = 8'h00;
        hcount_in = 11'd0; vcount_in = 10'd0;
        cyc(3);
        chk("play_no_flash", 32'(pixel_out), 32'h112233);
        player_health_in = 3'd2;
        step();
        chk("flash_start", 32'(flash_active_out), 32'd1);
        cnt = 8'(FLASH_N);
        for (int f = 0; f < FLASH_N; f++) begin
            cyc(3);
            fexp = cnt[1] ? 24'hFF2233 : 24'h112233;
            chk("flash_active", 32'(flash_active_out), 32'd1);
            chk("flash_pixel", 32'(pixel_out), 32'(fexp));
            nf_pulse();
            cnt = cnt - 8'd1;
        end
        chk("flash_end", 32'(flash_active_out), 32'd0);
        player_health_in = 3'd3;
        cyc(3);
        chk("heal_no_flash", 32'(flash_active_out), 32'd0);
        chk("heal_pixel", 32'(pixel_out), 32'h112233);

        // GAME_OVER entry, dim, hold timer
        opponent_health_in = 3'd0;
        nf_in = 1'b1;
        step();
        nf_in = 1'b0;
        chk("play_to_over", 32'(screen_state_out), 32'd2);
        chk("over_flash_clr", 32'(flash_active_out), 32'd0);
        cyc(3);
        chk("over_dim", 32'(pixel_out), 32'h081119);
        for (int f = 0; f < HOLD_N - 1; f++) nf_pulse();
        ir_send(CODE_A);
        chk("over_hold_59", 32'(screen_state_out), 32'd2);
        nf_pulse();
        ir_send(CODE_B);
        chk("over_to_start", 32'(screen_state_out), 32'd0);
        start_pixel_in = 24'h5A5A5A;
        cyc(3);
        chk("restart_pixel", 32'(pixel_out), 32'h5A5A5A);

        // Back to GAME_OVER, then asynchronous reset mid-cycle
        ir_send(CODE_A);
        chk("restart_play", 32'(screen_state_out), 32'd1);
        nf_in = 1'b1;
        step();
        nf_in = 1'b0;
        chk("over_again", 32'(screen_state_out), 32'd2);
        cyc(3);
        chk("over_dim2", 32'(pixel_out), 32'h081119);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_pixel", 32'(pixel_out), 32'h0);
        chk("async_rst_state", 32'(screen_state_out), 32'd0);
        chk("async_rst_flash", 32'(flash_active_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
